pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Front-end pipeline sequencer for the 5-stage LEGv8 CPU. Drives the IF/ID register hold (its Hazard input), the PC write hold, the ID/EX bubble and the IF/ID flush.
- Resolves three hazard types:
  - load-use data hazards;
  - taken branches, which are resolved in ID;
  - multi-cycle ops such as MUL, which occupy EX for MC_LATENCY cycles.
- Keeps a saturating stall-cycle performance counter.

Parameters:
MC_LATENCY, 4, total EX occupancy in cycles of a multi-cycle op (>=1)
CNT_W, 32, stall counter width

Ports:
clk  in  1  system clock; state updates on rising edge
reset  in  1  asynchronous, active-high reset
id_rn  in  5  Rn field of instruction in ID
id_rm  in  5  Rm/Rt field of instruction in ID
id_use_rn  in  1  ID instruction reads Rn
id_use_rm  in  1  ID instruction reads Rm/Rt
id_mc_op  in  1  ID instruction is a multi-cycle op
ex_mem_read  in  1  EX instruction is a load
ex_rd  in  5  destination register of EX instruction
br_taken  in  1  branch in ID resolved taken
ifid_hold  out  1  to IF/ID Hazard input; 1 = IF/ID keeps contents
pc_hold  out  1  1 = PC not updated
idex_bubble  out  1  1 = ID/EX loads a NOP (all control zero)
ifid_flush  out  1  1 = IF/ID loads a NOP instead of fetched word
busy  out  1  1 while in MC_WAIT
stall_cycles  out  CNT_W  count of cycles with ifid_hold=1

Behaviour:
- Clocking and output timing:
  - Control outputs are combinational from state and inputs.
  - The FSM and counter update on posedge clk.
  - Outputs must settle within the first half-cycle, because IF/ID samples on negedge clk.
- Reset:
  - While reset=1: state=RUN, count=0, stall_cycles=0.
  - All control outputs and busy are forced to 0.
  - An assertion mid-MC_WAIT aborts immediately, with no residual stall.
- load_use is true when all of the following hold:
  - ex_mem_read=1;
  - ex_rd != XZR (31);
  - (id_use_rn and id_rn==ex_rd) or (id_use_rm and id_rm==ex_rd).
- State RUN, evaluated in priority order:
  1. br_taken=1: ifid_flush=1, idex_bubble=0, no hold. This holds even if load_use is also true: the branch is evaluated in ID, so that case cannot arise; if it does, the flush wins and the hazard is dropped.
  2. Else if load_use: ifid_hold=pc_hold=idex_bubble=1 for exactly this cycle. State stays RUN. On the next cycle the bubble in EX clears load_use.
  3. Else if id_mc_op and MC_LATENCY>1: the op issues this cycle with no stall. Next state is MC_WAIT with count=MC_LATENCY-2.
  4. Else: all control outputs 0.
- State MC_WAIT:
  - ifid_hold=pc_hold=idex_bubble=1, busy=1.
  - br_taken is masked; the branch stays in ID and is re-evaluated in RUN.
  - load_use is ignored.
  - If count==0, next state is RUN; else count decrements.
  - A multi-cycle op therefore causes exactly MC_LATENCY-1 stall cycles.
- MC_LATENCY=1: MC_WAIT is never entered.
- stall_cycles:
  - Increments by 1 on each posedge where ifid_hold=1.
  - Saturates at 2^CNT_W-1 with no wrap.
- Count register width: clog2(MC_LATENCY) bits, minimum 1.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - localparam XZR = 5'd31;
  - state encoding {RUN, MC_WAIT};
  - a NOP control-word constant, shared with the ID/EX register.
- One sub-module: load_use_detect, the purely combinational comparator producing load_use.

Test Plan:
- Reset mid-MC_WAIT (MC_LATENCY=4, reset asserted in 2nd wait cycle) -> all outputs 0 asynchronously, busy=0, stall_cycles=0; after release, idle inputs give 0 stalls.
- Load-use: ex_mem_read=1, ex_rd=5, id_rn=5, id_use_rn=1 -> ifid_hold=pc_hold=idex_bubble=1 for one cycle; stall_cycles=1. Same with ex_rd=31 -> no stall. Same with id_use_rn=0 -> no stall.
- Multi-cycle op: id_mc_op=1 for one cycle, MC_LATENCY=4 -> no stall in issue cycle, then exactly 3 cycles of hold+bubble with busy=1, then RUN; stall_cycles=3.
- Branch: br_taken=1 with load_use conditions true -> ifid_flush=1, ifid_hold=0, idex_bubble=0; br_taken during MC_WAIT -> ifid_flush=0 until RUN.
- Counter saturation with CNT_W=3: 10 consecutive load-use stall cycles -> stall_cycles stops at 7.
- Back-to-back: multi-cycle op followed by a load-use in the same ID instruction after MC_WAIT -> 3 MC stalls then 1 load-use stall; total stall_cycles=4.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared control types for the LEGv8 front end.
// Used by the hazard sequencer and the ID/EX register.
package cpu_ctrl_pkg;

  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic       reg2loc;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat > 2) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard sequencer bundle: ID/EX operand info in, stall controls out.
// master = pipeline side, slave = sequencer side.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rn;
  logic [4:0]       id_rm;
  logic             id_use_rn;
  logic             id_use_rm;
  logic             id_mc_op;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             br_taken;
  logic             ifid_hold;
  logic             pc_hold;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             busy;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rn, id_rm, id_use_rn, id_use_rm, id_mc_op,
    output ex_mem_read, ex_rd, br_taken,
    input  ifid_hold, pc_hold, idex_bubble, ifid_flush,
    input  busy, stall_cycles
  );

  modport slave (
    input  id_rn, id_rm, id_use_rn, id_use_rm, id_mc_op,
    input  ex_mem_read, ex_rd, br_taken,
    output ifid_hold, pc_hold, idex_bubble, ifid_flush,
    output busy, stall_cycles
  );
endinterface

// File: rtl/load_use_detect.sv
// Load-use comparator: EX load feeds a source read in ID.
// XZR never carries a real dependency.
module load_use_detect
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] id_rn_i,
  input  logic [4:0] id_rm_i,
  input  logic       id_use_rn_i,
  input  logic       id_use_rm_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_i,
  output logic       load_use_o
);
  logic rn_hit;
  logic rm_hit;

  assign rn_hit = id_use_rn_i && (id_rn_i == ex_rd_i);
  assign rm_hit = id_use_rm_i && (id_rm_i == ex_rd_i);

  assign load_use_o = ex_mem_read_i && (ex_rd_i != XZR)
                    && (rn_hit || rm_hit);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Front-end hazard sequencer: load-use, ID branch flush, multi-cycle EX.
// Controls are combinational so they settle before the IF/ID negedge.
module pipe_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int CW = cnt_width(MC_LATENCY);
  localparam int CNT_INIT = (MC_LATENCY > 1) ? MC_LATENCY - 2 : 0;
  localparam logic [CW-1:0] CNT_LOAD = CW'(CNT_INIT);

  hz_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic load_use;
  logic hold;
  logic flush;
  logic busy;

  load_use_detect u_lud (
    .id_rn_i       (hz.id_rn),
    .id_rm_i       (hz.id_rm),
    .id_use_rn_i   (hz.id_use_rn),
    .id_use_rm_i   (hz.id_use_rm),
    .ex_mem_read_i (hz.ex_mem_read),
    .ex_rd_i       (hz.ex_rd),
    .load_use_o    (load_use)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold    = 1'b0;
    flush   = 1'b0;
    busy    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (hz.br_taken) begin
          flush = 1'b1;
        end else if (load_use) begin
          hold = 1'b1;
        end else if (hz.id_mc_op && (MC_LATENCY > 1)) begin
          state_d = MC_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      MC_WAIT: begin
        // branch and load-use wait here; RUN re-evaluates them
        hold = 1'b1;
        busy = 1'b1;
        if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (hold && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign hz.ifid_hold    = hold && !reset;
  assign hz.pc_hold      = hold && !reset;
  assign hz.idex_bubble  = hold && !reset;
  assign hz.ifid_flush   = flush && !reset;
  assign hz.busy         = busy && !reset;
  assign hz.stall_cycles = stall_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MC_LATENCY=4/CNT_W=3 and
// MC_LATENCY=1/CNT_W=32 instances sharing one stimulus).
module tb_pipe_hazard_ctrl;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  pipe_hazard_ctrl_if #(.CNT_W(3))  h0 ();
  pipe_hazard_ctrl_if #(.CNT_W(32)) h1 ();

  pipe_hazard_ctrl #(.MC_LATENCY(4), .CNT_W(3)) u0 (
    .clk   (clk),
    .reset (reset),
    .hz    (h0.slave)
  );

  pipe_hazard_ctrl #(.MC_LATENCY(1), .CNT_W(32)) u1 (
    .clk   (clk),
    .reset (reset),
    .hz    (h1.slave)
  );

  assign h1.id_rn       = h0.id_rn;
  assign h1.id_rm       = h0.id_rm;
  assign h1.id_use_rn   = h0.id_use_rn;
  assign h1.id_use_rm   = h0.id_use_rm;
  assign h1.id_mc_op    = h0.id_mc_op;
  assign h1.ex_mem_read = h0.ex_mem_read;
  assign h1.ex_rd       = h0.ex_rd;
  assign h1.br_taken    = h0.br_taken;

  // {ifid_hold, pc_hold, idex_bubble, ifid_flush, busy}
  logic [4:0] ctl0, ctl1;
  assign ctl0 = {h0.ifid_hold, h0.pc_hold, h0.idex_bubble,
                 h0.ifid_flush, h0.busy};
  assign ctl1 = {h1.ifid_hold, h1.pc_hold, h1.idex_bubble,
                 h1.ifid_flush, h1.busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    h0.id_rn       = 5'd0;
    h0.id_rm       = 5'd0;
    h0.id_use_rn   = 1'b0;
    h0.id_use_rm   = 1'b0;
    h0.id_mc_op    = 1'b0;
    h0.ex_mem_read = 1'b0;
    h0.ex_rd       = 5'd0;
    h0.br_taken    = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic use_rn);
    h0.ex_mem_read = 1'b1;
    h0.ex_rd       = rd;
    h0.id_rn       = 5'd5;
    h0.id_use_rn   = use_rn;
  endtask

  task automatic rst_pulse;
    tick();
    idle();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle();
    #2;
    n_chk++;
    if (ctl0 !== 5'b00000) begin
      n_fail++;
      $display("FAIL reset_ctl got=%b exp=%b", ctl0, 5'b00000);
    end
    n_chk++;
    if (h0.stall_cycles !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_cnt got=%0d exp=0", h0.stall_cycles);
    end
    n_chk++;
    if (h1.stall_cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_cnt1 got=%0d exp=0", h1.stall_cycles);
    end
    reset = 1'b0;
  endtask

  task automatic test_load_use;
    rst_pulse();
    set_lu(5'd5, 1'b1);
    #1;
    n_chk++;
    if (ctl0 !== 5'b11100) begin
      n_fail++;
      $display("FAIL lu_stall got=%b exp=%b", ctl0, 5'b11100);
    end
    tick();
    idle();
    #1;
    n_chk++;
    if (ctl0 !== 5'b00000 || h0.stall_cycles !== 3'd1) begin
      n_fail++;
      $display("FAIL lu_after ctl=%b cnt=%0d exp=00000/1",
               ctl0, h0.stall_cycles);
    end
    set_lu(5'd31, 1'b1);
    h0.id_rn = 5'd31;
    #1;
    n_chk++;
    if (ctl0 !== 5'b00000) begin
      n_fail++;
      $display("FAIL lu_xzr got=%b exp=%b", ctl0, 5'b00000);
    end
    tick();
    set_lu(5'd5, 1'b0);
    #1;
    n_chk++;
    if (ctl0 !== 5'b00000) begin
      n_fail++;
      $display("FAIL lu_nouse got=%b exp=%b", ctl0, 5'b00000);
    end
    h0.id_rm     = 5'd5;
    h0.id_use_rm = 1'b1;
    #1;
    n_chk++;
    if (ctl0 !== 5'b11100) begin
      n_fail++;
      $display("FAIL lu_rm got=%b exp=%b", ctl0, 5'b11100);
    end
    tick();
    idle();
    #1;
    n_chk++;
    if (h0.stall_cycles !== 3'd2) begin
      n_fail++;
      $display("FAIL lu_cnt got=%0d exp=2", h0.stall_cycles);
    end
  endtask

  task automatic test_mc_op;
    rst_pulse();
    h0.id_mc_op = 1'b1;
    #1;
    n_chk++;
    if (ctl0 !== 5'b00000) begin
      n_fail++;
      $display("FAIL mc_issue got=%b exp=%b", ctl0, 5'b00000);
    end
    tick();
    h0.id_mc_op = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if (ctl0 !== 5'b11101) begin
        n_fail++;
        $display("FAIL mc_wait%0d got=%b exp=%b", i, ctl0, 5'b11101);
      end
      tick();
    end
    #1;
    n_chk++;
    if (ctl0 !== 5'b00000 || h0.stall_cycles !== 3'd3) begin
      n_fail++;
      $display("FAIL mc_done ctl=%b cnt=%0d exp=00000/3",
               ctl0, h0.stall_cycles);
    end
  endtask

  task automatic test_branch;
    rst_pulse();
    set_lu(5'd5, 1'b1);
    h0.br_taken = 1'b1;
    #1;
    n_chk++;
    if (ctl0 !== 5'b00010) begin
      n_fail++;
      $display("FAIL br_flush got=%b exp=%b", ctl0, 5'b00010);
    end
    tick();
    idle();
    h0.id_mc_op = 1'b1;
    #1;
    n_chk++;
    if (h0.stall_cycles !== 3'd0) begin
      n_fail++;
      $display("FAIL br_cnt got=%0d exp=0", h0.stall_cycles);
    end
    tick();
    h0.id_mc_op = 1'b0;
    h0.br_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if (ctl0 !== 5'b11101) begin
        n_fail++;
        $display("FAIL br_mask%0d got=%b exp=%b", i, ctl0, 5'b11101);
      end
      tick();
    end
    #1;
    n_chk++;
    if (ctl0 !== 5'b00010) begin
      n_fail++;
      $display("FAIL br_run got=%b exp=%b", ctl0, 5'b00010);
    end
    idle();
  endtask

  task automatic test_reset_mid_wait;
    rst_pulse();
    h0.id_mc_op = 1'b1;
    tick();
    h0.id_mc_op = 1'b0;
    tick();
    n_chk++;
    if (ctl0 !== 5'b11101 || h0.stall_cycles !== 3'd1) begin
      n_fail++;
      $display("FAIL rmid_pre ctl=%b cnt=%0d exp=11101/1",
               ctl0, h0.stall_cycles);
    end
    reset = 1'b1;
    #1;
    n_chk++;
    if (ctl0 !== 5'b00000 || h0.stall_cycles !== 3'd0) begin
      n_fail++;
      $display("FAIL rmid_async ctl=%b cnt=%0d exp=00000/0",
               ctl0, h0.stall_cycles);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (ctl0 !== 5'b00000 || h0.stall_cycles !== 3'd0) begin
        n_fail++;
        $display("FAIL rmid_post%0d ctl=%b cnt=%0d exp=00000/0",
                 i, ctl0, h0.stall_cycles);
      end
    end
  endtask

  task automatic test_saturation;
    logic [2:0] exp;
    rst_pulse();
    set_lu(5'd5, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      exp = (i + 1 > 7) ? 3'd7 : 3'(i + 1);
      n_chk++;
      if (h0.stall_cycles !== exp) begin
        n_fail++;
        $display("FAIL sat%0d got=%0d exp=%0d", i, h0.stall_cycles, exp);
      end
    end
    idle();
  endtask

  task automatic test_back_to_back;
    rst_pulse();
    h0.id_mc_op = 1'b1;
    #1;
    n_chk++;
    if (ctl0 !== 5'b00000) begin
      n_fail++;
      $display("FAIL b2b_issue got=%b exp=%b", ctl0, 5'b00000);
    end
    tick();
    h0.id_mc_op = 1'b0;
    set_lu(5'd5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if (ctl0 !== 5'b11101) begin
        n_fail++;
        $display("FAIL b2b_wait%0d got=%b exp=%b", i, ctl0, 5'b11101);
      end
      tick();
    end
    #1;
    n_chk++;
    if (ctl0 !== 5'b11100) begin
      n_fail++;
      $display("FAIL b2b_lu got=%b exp=%b", ctl0, 5'b11100);
    end
    tick();
    idle();
    #1;
    n_chk++;
    if (ctl0 !== 5'b00000 || h0.stall_cycles !== 3'd4) begin
      n_fail++;
      $display("FAIL b2b_total ctl=%b cnt=%0d exp=00000/4",
               ctl0, h0.stall_cycles);
    end
  endtask

  task automatic test_lat1;
    rst_pulse();
    h0.id_mc_op = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++;
      if (ctl1 !== 5'b00000) begin
        n_fail++;
        $display("FAIL lat1_%0d got=%b exp=%b", i, ctl1, 5'b00000);
      end
      tick();
    end
    n_chk++;
    if (h1.stall_cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL lat1_cnt got=%0d exp=0", h1.stall_cycles);
    end
    idle();
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_load_use();
    test_mc_op();
    test_branch();
    test_reset_mid_wait();
    test_saturation();
    test_back_to_back();
    test_lat1();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
